// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// The busy scoreboard is compiled in only with REGFILE_SCOREBOARD_EN.
package regfile_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NOP_ADDR   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-producer flags; built only with REGFILE_SCOREBOARD_EN.
// An alloc and a write to the same register in one cycle leave the register busy.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_run,
   input  logic                           i_alloc_en,
   input  logic [ADDR_W-1:0]              i_alloc_addr,
   input  logic [NUM_WR-1:0]              i_wr_q,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  i_waddr,
   input  logic [NUM_RD-1:0]              i_ren,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_raddr,
   output logic [NUM_RD-1:0]              o_busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [NUM_RD-1:0] wr_hit;

   // Clears are applied first so that a same-cycle alloc overrides them.
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < NUM_WR; k++) begin
         if (i_wr_q[k]) busy_nxt[i_waddr[k]] = 1'b0;
      end
      if (i_alloc_en && (i_alloc_addr != ADDR_W'(NOP_ADDR))) busy_nxt[i_alloc_addr] = 1'b1;
      busy_nxt[NOP_ADDR] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy <= '0;
      end else if (i_run) begin
         busy <= busy_nxt;
      end
   end

   always_comb begin
      wr_hit = '0;
      o_busy = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_q[k] && (i_waddr[k] == i_raddr[j])) wr_hit[j] = 1'b1;
         end
         o_busy[j] = i_run & i_ren[j] & busy[i_raddr[j]] & ~wr_hit[j];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass and a post-reset zeroing sweep.
// Define REGFILE_SCOREBOARD_EN to build the per-register busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   output logic                           o_ready,
   input  logic [NUM_WR-1:0]              i_wen,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  i_waddr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  i_wdata,
   input  logic [NUM_RD-1:0]              i_ren,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_raddr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  o_rdata,
   input  logic                           i_alloc_en,
   input  logic [ADDR_W-1:0]              i_alloc_addr,
   output logic [NUM_RD-1:0]              o_busy,
   output logic                           o_dbg_state
);

   localparam int DEPTH = 2**ADDR_W;

   state_e             state;
   logic [ADDR_W-1:0]  cnt;
   logic               ready;
   logic [DATA_W-1:0]  regs [DEPTH];
   logic [NUM_WR-1:0]  wr_q;

   assign ready       = (state == RUN);
   assign o_ready     = ready;
   assign o_dbg_state = state;

   // Sweep starts at 1: register 0 is never stored, it is forced to 0 on read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= INIT;
         cnt   <= ADDR_W'(1);
      end else if (state == INIT) begin
         cnt <= cnt + ADDR_W'(1);
         if (cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
      end
   end

   always_comb begin
      wr_q = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         wr_q[k] = ready & i_wen[k] & (i_waddr[k] != ADDR_W'(NOP_ADDR));
      end
   end

   // Later ports are applied last, so the highest index wins on a collision.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state == INIT) begin
            regs[cnt] <= '0;
         end else begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_q[k]) regs[i_waddr[k]] <= i_wdata[k];
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         if (ready && i_ren[j] && (i_raddr[j] != ADDR_W'(NOP_ADDR))) begin
            o_rdata[j] = regs[i_raddr[j]];
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_q[k] && (i_waddr[k] == i_raddr[j])) o_rdata[j] = i_wdata[k];
            end
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_run        (ready),
      .i_alloc_en   (i_alloc_en),
      .i_alloc_addr (i_alloc_addr),
      .i_wr_q       (wr_q),
      .i_waddr      (i_waddr),
      .i_ren        (i_ren),
      .i_raddr      (i_raddr),
      .o_busy       (o_busy)
   );
`else
   logic unused_alloc;
   assign unused_alloc = ^{i_alloc_en, i_alloc_addr};
   assign o_busy       = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: drivers queue expected outputs, a negedge monitor checks them.
// Busy expectations follow REGFILE_SCOREBOARD_EN.
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;

`ifdef REGFILE_SCOREBOARD_EN
   localparam logic [DATA_W-1:0] SB_BUSY = 1;
`else
   localparam logic [DATA_W-1:0] SB_BUSY = 0;
`endif

   localparam int SEL_RDATA = 0;
   localparam int SEL_BUSY  = 1;
   localparam int SEL_READY = 2;
   localparam int SEL_STATE = 3;

   logic                           i_clk;
   logic                           i_rst;
   logic                           o_ready;
   logic [NUM_WR-1:0]              i_wen;
   logic [NUM_WR-1:0][ADDR_W-1:0]  i_waddr;
   logic [NUM_WR-1:0][DATA_W-1:0]  i_wdata;
   logic [NUM_RD-1:0]              i_ren;
   logic [NUM_RD-1:0][ADDR_W-1:0]  i_raddr;
   logic [NUM_RD-1:0][DATA_W-1:0]  o_rdata;
   logic                           i_alloc_en;
   logic [ADDR_W-1:0]              i_alloc_addr;
   logic [NUM_RD-1:0]              o_busy;
   logic                           o_dbg_state;

   typedef struct {
      string             name;
      int                sel;
      int                port;
      logic [DATA_W-1:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   regfile_mp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .o_ready      (o_ready),
      .i_wen        (i_wen),
      .i_waddr      (i_waddr),
      .i_wdata      (i_wdata),
      .i_ren        (i_ren),
      .i_raddr      (i_raddr),
      .o_rdata      (o_rdata),
      .i_alloc_en   (i_alloc_en),
      .i_alloc_addr (i_alloc_addr),
      .o_busy       (o_busy),
      .o_dbg_state  (o_dbg_state)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // driver tasks
   task automatic idle();
      i_wen        = '0;
      i_waddr      = '0;
      i_wdata      = '0;
      i_ren        = '0;
      i_raddr      = '0;
      i_alloc_en   = 1'b0;
      i_alloc_addr = '0;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect_v(input string name, input int sel, input int port, input logic [DATA_W-1:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.port = port;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic wr(input int p, input int a, input logic [DATA_W-1:0] d);
      i_wen[p]   = 1'b1;
      i_waddr[p] = ADDR_W'(a);
      i_wdata[p] = d;
   endtask

   task automatic rd(input int p, input int a);
      i_ren[p]   = 1'b1;
      i_raddr[p] = ADDR_W'(a);
   endtask

   task automatic alloc(input int a);
      i_alloc_en   = 1'b1;
      i_alloc_addr = ADDR_W'(a);
   endtask

   // Entered just after the reset edge; ready must stay low for 31 edges.
   task automatic sweep(input string name);
      for (int i = 0; i < 31; i++) begin
         expect_v(name, SEL_READY, 0, 0);
         step();
      end
      idle();
      expect_v(name, SEL_READY, 0, 1);
      expect_v({name, "_state"}, SEL_STATE, 0, 1);
   endtask

   // scoreboard / monitor
   always @(negedge i_clk) begin
      while (exp_q.size() > 0) begin
         exp_t              e;
         logic [DATA_W-1:0] act;
         e = exp_q.pop_front();
         case (e.sel)
            SEL_RDATA: act = o_rdata[e.port];
            SEL_BUSY:  act = {{(DATA_W-1){1'b0}}, o_busy[e.port]};
            SEL_READY: act = {{(DATA_W-1){1'b0}}, o_ready};
            default:   act = {{(DATA_W-1){1'b0}}, o_dbg_state};
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s port%0d: got %h expected %h at %0t", e.name, e.port, act, e.val, $time);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      idle();
      i_rst = 1'b1;
      step();
      step();

      // reset state, read during INIT, full sweep
      i_rst = 1'b0;
      rd(0, 3);
      expect_v("rst_state", SEL_STATE, 0, 0);
      expect_v("rst_rdata", SEL_RDATA, 0, 0);
      expect_v("rst_busy", SEL_BUSY, 0, 0);
      sweep("sweep1");
      step();

      for (int a = 1; a < 32; a += 2) begin
         idle();
         rd(0, a);
         rd(1, (a % 31) + 1);
         expect_v("zero_rd0", SEL_RDATA, 0, 0);
         expect_v("zero_rd1", SEL_RDATA, 1, 0);
         step();
      end

      // same-cycle bypass, then array read
      idle(); wr(0, 5, 32'hDEADBEEF); rd(1, 5);
      expect_v("bypass5", SEL_RDATA, 1, 32'hDEADBEEF);
      step();
      idle(); rd(0, 5); rd(1, 5);
      expect_v("array5_p0", SEL_RDATA, 0, 32'hDEADBEEF);
      expect_v("array5_p1", SEL_RDATA, 1, 32'hDEADBEEF);
      step();

      // write-port collision: port 1 wins
      idle(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7);
      expect_v("coll7_bypass", SEL_RDATA, 0, 32'h2222);
      step();
      idle(); rd(0, 7); rd(1, 7);
      expect_v("coll7_p0", SEL_RDATA, 0, 32'h2222);
      expect_v("coll7_p1", SEL_RDATA, 1, 32'h2222);
      step();

      // independent writes on both ports
      idle(); wr(0, 10, 32'hAAAA); wr(1, 11, 32'hBBBB); rd(0, 10); rd(1, 11);
      expect_v("byp10", SEL_RDATA, 0, 32'hAAAA);
      expect_v("byp11", SEL_RDATA, 1, 32'hBBBB);
      step();
      idle(); rd(0, 11); rd(1, 10);
      expect_v("arr11", SEL_RDATA, 0, 32'hBBBB);
      expect_v("arr10", SEL_RDATA, 1, 32'hAAAA);
      step();

      // register 0 and disabled read port
      idle(); wr(0, 0, 32'hFFFFFFFF); rd(1, 0);
      expect_v("r0_bypass", SEL_RDATA, 1, 0);
      step();
      idle(); rd(0, 0); i_raddr[1] = ADDR_W'(5);
      expect_v("r0_array", SEL_RDATA, 0, 0);
      expect_v("ren_off", SEL_RDATA, 1, 0);
      step();

      // scoreboard
      idle(); alloc(9); rd(0, 9);
      expect_v("alloc9_same", SEL_BUSY, 0, 0);
      step();
      idle(); rd(0, 9); i_raddr[1] = ADDR_W'(9);
      expect_v("alloc9_next", SEL_BUSY, 0, SB_BUSY);
      expect_v("alloc9_ren0", SEL_BUSY, 1, 0);
      step();
      idle(); wr(1, 9, 32'h55); rd(0, 9);
      expect_v("wr9_busy", SEL_BUSY, 0, 0);
      expect_v("wr9_data", SEL_RDATA, 0, 32'h55);
      step();
      idle(); rd(0, 9);
      expect_v("wr9_busy_after", SEL_BUSY, 0, 0);
      expect_v("wr9_data_after", SEL_RDATA, 0, 32'h55);
      step();
      idle(); alloc(9); wr(0, 9, 32'h66); rd(1, 9);
      expect_v("setwin_busy", SEL_BUSY, 1, 0);
      expect_v("setwin_data", SEL_RDATA, 1, 32'h66);
      step();
      idle(); rd(1, 9);
      expect_v("setwin_busy_after", SEL_BUSY, 1, SB_BUSY);
      expect_v("setwin_data_after", SEL_RDATA, 1, 32'h66);
      step();
      idle(); alloc(0);
      step();
      idle(); rd(0, 0);
      expect_v("alloc0", SEL_BUSY, 0, 0);
      step();
      idle(); alloc(12);
      step();
      idle(); rd(0, 12);
      expect_v("alloc12", SEL_BUSY, 0, SB_BUSY);
      step();

      // reset mid-sweep at cycle 10
      idle(); i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         expect_v("mid_ready", SEL_READY, 0, 0);
         step();
      end
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      sweep("sweep_mid");
      step();
      idle(); rd(0, 12); rd(1, 5);
      expect_v("busy12_cleared", SEL_BUSY, 0, 0);
      expect_v("data5_cleared", SEL_RDATA, 1, 0);
      step();

      // reset in RUN; writes and allocs during INIT are ignored
      idle(); wr(0, 3, 32'hA5);
      step();
      idle(); rd(0, 3);
      expect_v("run3", SEL_RDATA, 0, 32'hA5);
      step();
      idle(); i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      rd(0, 3); wr(1, 4, 32'h77); alloc(4);
      expect_v("init3_rdata", SEL_RDATA, 0, 0);
      sweep("sweep_run");
      step();
      idle(); rd(0, 3); rd(1, 4);
      expect_v("after3", SEL_RDATA, 0, 0);
      expect_v("after4_data", SEL_RDATA, 1, 0);
      expect_v("after4_busy", SEL_BUSY, 1, 0);
      step();

      step();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
